uart_mem_arbiter: RTL and testbench

UART_MEM_ARBITER -- requirements
Module: uart_mem_arbiter

---
 rtl/uart_mem_arbiter_pkg.sv | 19 +
 rtl/uart_mem_arbiter_if.sv | 31 +++
 rtl/uart_mem_arbiter_rr_picker.sv | 24 ++
 rtl/uart_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_arbiter_pkg.sv
// Shared constants and types for the UART / data-memory arbiter.
package uart_mem_arbiter_pkg;

    // Default data-memory address width and memory-map anchors.
    localparam int DATA_MEM_ADDR_SIZE = 12;
    localparam int UART0_ADDR         = 'hF00;
    localparam int RX_BASE_ADDR       = 'h800;
    localparam int FLAG_VALUE_DEF     = 'h0C;

    // Channel index width covers the full 1..8 channel range.
    localparam int CH_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_FLAG = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_mem_arbiter_if.sv
// CPU store port, UART channel signals and data-memory write port.
interface uart_mem_arbiter_if
    import uart_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = DATA_MEM_ADDR_SIZE,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0]        cpu_address;
    logic                     cpu_mem_write;
    logic [DATA_W-1:0]        cpu_write_data;
    logic                     cpu_stall;
    logic [NUM_CH-1:0]        rx_ready;
    logic [NUM_CH*DATA_W-1:0] rx_data;
    logic [NUM_CH-1:0]        tx_busy;
    logic [NUM_CH-1:0]        tx_enable;
    logic [NUM_CH-1:0]        rx_clear;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_address;
    logic [DATA_W-1:0]        mem_write_data;

    modport slave (
        input  cpu_address, cpu_mem_write, cpu_write_data, rx_ready, rx_data, tx_busy,
        output cpu_stall, tx_enable, rx_clear, mem_write, mem_address, mem_write_data
    );

    modport master (
        output cpu_address, cpu_mem_write, cpu_write_data, rx_ready, rx_data, tx_busy,
        input  cpu_stall, tx_enable, rx_clear, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/uart_mem_arbiter_rr_picker.sv
// Round-robin picker: first requesting channel after the last granted one.
module rr_picker
    import uart_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] last,
    output logic                req_any,
    output logic [CH_IDX_W-1:0] grant_idx
);

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        req_any   = |req;
        grant_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[(int'(last) + i) % NUM_CH]) begin
                grant_idx = CH_IDX_W'((int'(last) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Arbitrates CPU stores (TX starts or memory writes) against UART RX bytes
// that are deposited as a data/flag pair in data memory.
//
// state   | meaning
// IDLE    | accept a CPU store or grant one RX channel
// WR_DATA | RX byte on the memory port, flag queued next
// WR_FLAG | flag byte on the memory port, back to IDLE
module uart_mem_arbiter
    import uart_mem_arbiter_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                ADDR_W     = DATA_MEM_ADDR_SIZE,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] TX_BASE    = ADDR_W'(UART0_ADDR),
    parameter logic [ADDR_W-1:0] RX_BASE    = ADDR_W'(RX_BASE_ADDR),
    parameter logic [DATA_W-1:0] FLAG_VALUE = DATA_W'(FLAG_VALUE_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    uart_mem_arbiter_if.slave  bus
);

    arb_state_t          state, state_nxt;
    logic                rx_turn;
    logic [CH_IDX_W-1:0] last_grant, cur_grant, pick_idx;
    logic                pick_any;
    logic [NUM_CH-1:0]   tx_sel;
    logic                tx_hit, tx_target_busy;
    logic                stall_cond, accept, grant;
    logic [ADDR_W-1:0]   tx_offset;
    logic [DATA_W-1:0]   pick_byte;

    rr_picker #(.NUM_CH(NUM_CH)) u_picker (
        .req       (bus.rx_ready),
        .last      (last_grant),
        .req_any   (pick_any),
        .grant_idx (pick_idx)
    );

    // Decode TX targets and select the granted channel's RX byte.
    always_comb begin
        tx_offset = bus.cpu_address - TX_BASE;
        tx_sel    = '0;
        pick_byte = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tx_sel[c] = (tx_offset == ADDR_W'(c));
            if (pick_idx == CH_IDX_W'(c)) begin
                pick_byte = bus.rx_data[c*DATA_W +: DATA_W];
            end
        end
        tx_hit         = |tx_sel;
        tx_target_busy = |(tx_sel & bus.tx_busy);
    end

    // Next-state, acceptance, grant and the single-cycle pulse outputs.
    always_comb begin
        state_nxt     = state;
        stall_cond    = (state != IDLE) | tx_target_busy | rx_turn;
        accept        = 1'b0;
        grant         = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.tx_enable = '0;
        bus.rx_clear  = '0;
        if (!reset) begin
            bus.cpu_stall = bus.cpu_mem_write & stall_cond;
            accept        = bus.cpu_mem_write & ~stall_cond;
            if (accept && tx_hit) begin
                bus.tx_enable = tx_sel;
            end
            case (state)
                IDLE: begin
                    if (pick_any && !accept) begin
                        grant                  = 1'b1;
                        bus.rx_clear[pick_idx] = 1'b1;
                        state_nxt              = WR_DATA;
                    end
                end
                WR_DATA: state_nxt = WR_FLAG;
                WR_FLAG: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, fairness bookkeeping and the registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            rx_turn            <= 1'b0;
            last_grant         <= CH_IDX_W'(NUM_CH - 1);
            cur_grant          <= '0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
        end else begin
            state         <= state_nxt;
            bus.mem_write <= 1'b0;
            if (accept && !tx_hit) begin
                bus.mem_write      <= 1'b1;
                bus.mem_address    <= bus.cpu_address;
                bus.mem_write_data <= bus.cpu_write_data;
            end
            if (grant) begin
                last_grant         <= pick_idx;
                cur_grant          <= pick_idx;
                rx_turn            <= 1'b0;
                bus.mem_write      <= 1'b1;
                bus.mem_address    <= RX_BASE + ADDR_W'({pick_idx, 1'b0});
                bus.mem_write_data <= pick_byte;
            end else if (accept && pick_any) begin
                rx_turn <= 1'b1;
            end
            if (state == WR_DATA) begin
                bus.mem_write      <= 1'b1;
                bus.mem_address    <= RX_BASE + ADDR_W'({cur_grant, 1'b1});
                bus.mem_write_data <= FLAG_VALUE;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter: a 2-channel and a 4-channel instance.
module tb_uart_mem_arbiter;

    logic clk;
    logic reset;
    int   vec;
    int   errs;

    uart_mem_arbiter_if #(.NUM_CH(2), .ADDR_W(12), .DATA_W(8)) b2 ();
    uart_mem_arbiter_if #(.NUM_CH(4), .ADDR_W(12), .DATA_W(8)) b4 ();

    uart_mem_arbiter #(.NUM_CH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
    uart_mem_arbiter #(.NUM_CH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs;
        b2.cpu_address = '0; b2.cpu_mem_write = 1'b0; b2.cpu_write_data = '0;
        b2.rx_ready = '0; b2.rx_data = '0; b2.tx_busy = '0;
        b4.cpu_address = '0; b4.cpu_mem_write = 1'b0; b4.cpu_write_data = '0;
        b4.rx_ready = '0; b4.rx_data = '0; b4.tx_busy = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        b2.rx_ready = 2'b01;
        b2.cpu_mem_write = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (b2.mem_write !== 1'b0 || b2.mem_address !== 12'h000 || b2.mem_write_data !== 8'h00) begin
            $display("FAIL reset_mem got we=%b a=%h d=%h want 0/000/00", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
        vec++;
        if (b2.rx_clear !== 2'b00 || b2.tx_enable !== 2'b00 || b2.cpu_stall !== 1'b0) begin
            $display("FAIL reset_pulses got clr=%b en=%b stall=%b want 00/00/0", b2.rx_clear, b2.tx_enable, b2.cpu_stall);
            errs++;
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_rx_single;
        do_reset();
        b2.rx_ready = 2'b01;
        b2.rx_data  = 16'h0041;
        #1;
        vec++;
        if (b2.rx_clear !== 2'b01 || b2.mem_write !== 1'b0) begin
            $display("FAIL rx_single_grant got clr=%b we=%b want 01/0", b2.rx_clear, b2.mem_write);
            errs++;
        end
        @(negedge clk);
        b2.rx_ready = 2'b00;
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'h800 || b2.mem_write_data !== 8'h41 || b2.rx_clear !== 2'b00) begin
            $display("FAIL rx_single_data got we=%b a=%h d=%h clr=%b want 1/800/41/00", b2.mem_write, b2.mem_address, b2.mem_write_data, b2.rx_clear);
            errs++;
        end
        @(negedge clk);
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'h801 || b2.mem_write_data !== 8'h0C) begin
            $display("FAIL rx_single_flag got we=%b a=%h d=%h want 1/801/0c", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
        @(negedge clk);
        #1;
        vec++;
        if (b2.mem_write !== 1'b0 || b2.mem_address !== 12'h801 || b2.mem_write_data !== 8'h0C) begin
            $display("FAIL rx_single_idle got we=%b a=%h d=%h want 0/801/0c", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
    endtask

    task automatic test_round_robin;
        int          order [3] = '{0, 1, 0};
        logic [7:0]  bytes [2] = '{8'hA1, 8'hB2};
        logic [11:0] ea;
        logic [1:0]  ec;
        do_reset();
        b2.rx_ready = 2'b11;
        b2.rx_data  = 16'hB2A1;
        for (int t = 0; t < 3; t++) begin
            ec = 2'b01 << order[t];
            ea = 12'h800 + 12'(2 * order[t]);
            #1;
            vec++;
            if (b2.rx_clear !== ec) begin
                $display("FAIL rr_grant%0d got clr=%b want %b", t, b2.rx_clear, ec);
                errs++;
            end
            @(negedge clk);
            #1;
            vec++;
            if (b2.mem_write !== 1'b1 || b2.mem_address !== ea || b2.mem_write_data !== bytes[order[t]]) begin
                $display("FAIL rr_data%0d got we=%b a=%h d=%h want 1/%h/%h", t, b2.mem_write, b2.mem_address, b2.mem_write_data, ea, bytes[order[t]]);
                errs++;
            end
            @(negedge clk);
            #1;
            vec++;
            if (b2.mem_write !== 1'b1 || b2.mem_address !== ea + 12'h1 || b2.mem_write_data !== 8'h0C) begin
                $display("FAIL rr_flag%0d got we=%b a=%h d=%h want 1/%h/0c", t, b2.mem_write, b2.mem_address, b2.mem_write_data, ea + 12'h1);
                errs++;
            end
            @(negedge clk);
        end
        b2.rx_ready = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx;
        do_reset();
        b2.cpu_address    = 12'hF01;
        b2.cpu_write_data = 8'h55;
        b2.cpu_mem_write  = 1'b1;
        b2.tx_busy        = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if (b2.cpu_stall !== 1'b1 || b2.tx_enable !== 2'b00 || b2.mem_write !== 1'b0) begin
                $display("FAIL tx_busy_stall%0d got stall=%b en=%b we=%b want 1/00/0", i, b2.cpu_stall, b2.tx_enable, b2.mem_write);
                errs++;
            end
            @(negedge clk);
        end
        b2.tx_busy = 2'b00;
        #1;
        vec++;
        if (b2.cpu_stall !== 1'b0 || b2.tx_enable !== 2'b10) begin
            $display("FAIL tx_start1 got stall=%b en=%b want 0/10", b2.cpu_stall, b2.tx_enable);
            errs++;
        end
        @(negedge clk);
        b2.cpu_address    = 12'hF00;
        b2.cpu_write_data = 8'h66;
        #1;
        vec++;
        if (b2.cpu_stall !== 1'b0 || b2.tx_enable !== 2'b01 || b2.mem_write !== 1'b0) begin
            $display("FAIL tx_start0 got stall=%b en=%b we=%b want 0/01/0", b2.cpu_stall, b2.tx_enable, b2.mem_write);
            errs++;
        end
        @(negedge clk);
        b2.cpu_address    = 12'hF02;
        b2.cpu_write_data = 8'h67;
        #1;
        vec++;
        if (b2.tx_enable !== 2'b00 || b2.cpu_stall !== 1'b0 || b2.mem_write !== 1'b0) begin
            $display("FAIL tx_out_of_range got en=%b stall=%b we=%b want 00/0/0", b2.tx_enable, b2.cpu_stall, b2.mem_write);
            errs++;
        end
        @(negedge clk);
        b2.cpu_mem_write = 1'b0;
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'hF02 || b2.mem_write_data !== 8'h67) begin
            $display("FAIL tx_oor_memwrite got we=%b a=%h d=%h want 1/f02/67", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
        @(negedge clk);
    endtask

    task automatic test_cpu_vs_rx;
        do_reset();
        b2.cpu_address    = 12'h010;
        b2.cpu_write_data = 8'h77;
        b2.cpu_mem_write  = 1'b1;
        b2.rx_ready       = 2'b01;
        b2.rx_data        = 16'h005A;
        #1;
        vec++;
        if (b2.cpu_stall !== 1'b0 || b2.rx_clear !== 2'b00) begin
            $display("FAIL mix_cpu_first got stall=%b clr=%b want 0/00", b2.cpu_stall, b2.rx_clear);
            errs++;
        end
        @(negedge clk);
        b2.cpu_address    = 12'h020;
        b2.cpu_write_data = 8'h88;
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'h010 || b2.mem_write_data !== 8'h77 || b2.rx_clear !== 2'b01 || b2.cpu_stall !== 1'b1) begin
            $display("FAIL mix_rx_turn got we=%b a=%h d=%h clr=%b stall=%b want 1/010/77/01/1", b2.mem_write, b2.mem_address, b2.mem_write_data, b2.rx_clear, b2.cpu_stall);
            errs++;
        end
        @(negedge clk);
        b2.rx_ready = 2'b00;
        #1;
        vec++;
        if (b2.mem_address !== 12'h800 || b2.mem_write_data !== 8'h5A || b2.cpu_stall !== 1'b1) begin
            $display("FAIL mix_rx_data got a=%h d=%h stall=%b want 800/5a/1", b2.mem_address, b2.mem_write_data, b2.cpu_stall);
            errs++;
        end
        @(negedge clk);
        #1;
        vec++;
        if (b2.mem_address !== 12'h801 || b2.mem_write_data !== 8'h0C || b2.cpu_stall !== 1'b1) begin
            $display("FAIL mix_rx_flag got a=%h d=%h stall=%b want 801/0c/1", b2.mem_address, b2.mem_write_data, b2.cpu_stall);
            errs++;
        end
        @(negedge clk);
        #1;
        vec++;
        if (b2.cpu_stall !== 1'b0 || b2.mem_write !== 1'b0) begin
            $display("FAIL mix_cpu_release got stall=%b we=%b want 0/0", b2.cpu_stall, b2.mem_write);
            errs++;
        end
        @(negedge clk);
        b2.cpu_mem_write = 1'b0;
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'h020 || b2.mem_write_data !== 8'h88) begin
            $display("FAIL mix_cpu_second got we=%b a=%h d=%h want 1/020/88", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_reset();
        b2.rx_ready = 2'b01;
        b2.rx_data  = 16'h0033;
        #1;
        vec++;
        if (b2.rx_clear !== 2'b01) begin
            $display("FAIL abort_grant got clr=%b want 01", b2.rx_clear);
            errs++;
        end
        @(negedge clk);
        b2.rx_ready = 2'b00;
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'h800 || b2.mem_write_data !== 8'h33) begin
            $display("FAIL abort_data got we=%b a=%h d=%h want 1/800/33", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vec++;
        if (b2.mem_write !== 1'b0 || b2.mem_address !== 12'h000 || b2.mem_write_data !== 8'h00 ||
            b2.rx_clear !== 2'b00 || b2.tx_enable !== 2'b00 || b2.cpu_stall !== 1'b0) begin
            $display("FAIL abort_outputs got we=%b a=%h d=%h clr=%b en=%b stall=%b want all 0",
                     b2.mem_write, b2.mem_address, b2.mem_write_data, b2.rx_clear, b2.tx_enable, b2.cpu_stall);
            errs++;
        end
        b2.cpu_address    = 12'h030;
        b2.cpu_write_data = 8'h99;
        b2.cpu_mem_write  = 1'b1;
        #1;
        vec++;
        if (b2.cpu_stall !== 1'b0) begin
            $display("FAIL abort_idle got stall=%b want 0", b2.cpu_stall);
            errs++;
        end
        @(negedge clk);
        b2.cpu_mem_write = 1'b0;
        #1;
        vec++;
        if (b2.mem_write !== 1'b1 || b2.mem_address !== 12'h030 || b2.mem_write_data !== 8'h99) begin
            $display("FAIL abort_noflag got we=%b a=%h d=%h want 1/030/99", b2.mem_write, b2.mem_address, b2.mem_write_data);
            errs++;
        end
        @(negedge clk);
    endtask

    task automatic test_four_channels;
        logic [3:0]  ec;
        logic [11:0] ea;
        logic [7:0]  ed;
        int          ch;
        do_reset();
        b4.rx_ready = 4'hF;
        b4.rx_data  = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            ch = k % 4;
            ec = 4'b0001 << ch;
            ea = 12'h800 + 12'(2 * ch);
            ed = 8'(8'h11 * (ch + 1));
            #1;
            vec++;
            if (b4.rx_clear !== ec) begin
                $display("FAIL four_grant%0d got clr=%b want %b", k, b4.rx_clear, ec);
                errs++;
            end
            @(negedge clk);
            #1;
            vec++;
            if (b4.mem_write !== 1'b1 || b4.mem_address !== ea || b4.mem_write_data !== ed) begin
                $display("FAIL four_data%0d got we=%b a=%h d=%h want 1/%h/%h", k, b4.mem_write, b4.mem_address, b4.mem_write_data, ea, ed);
                errs++;
            end
            repeat (2) @(negedge clk);
        end
        b4.rx_ready = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_rx_single();
        test_round_robin();
        test_tx();
        test_cpu_vs_rx();
        test_reset_mid();
        test_four_channels();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
